// File: rtl/muldiv_pkg.sv
// Shared op encodings and FSM state type for the iterative multiply/divide unit.
// The CPU control FSM imports the same op constants.
package muldiv_pkg;
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FIXUP = 2'b10,
        ST_DONE  = 2'b11
    } state_e;
endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the issuing master and the muldiv unit.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    op_e              op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             abort;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a_in, b_in, abort,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a_in, b_in, abort,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply (shift-add) and restoring divide on magnitudes,
// with a one-cycle sign fixup; results land on hi/lo only in the DONE cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic     clock,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_e             r_state, w_next;
    logic               r_is_div;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH:0]     r_acc;
    logic [WIDTH-1:0]   r_q, r_b;
    logic               r_neg_q, r_neg_r, r_dz;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_done, r_div_zero;

    logic               w_signed, w_a_neg, w_b_neg, w_is_div, w_b_zero, w_accept;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_mul_sum, w_trial;
    logic [WIDTH+1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

    assign w_signed = SIGNED_EN && !bus.op[0];
    assign w_a_neg  = w_signed && bus.a_in[WIDTH-1];
    assign w_b_neg  = w_signed && bus.b_in[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.a_in : bus.a_in;
    assign w_b_mag  = w_b_neg ? -bus.b_in : bus.b_in;
    assign w_is_div = bus.op[1];
    assign w_b_zero = (bus.b_in == '0);
    assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.abort;

    // Multiply keeps {acc, q} as the running product; divide keeps {rem, quotient}.
    assign w_mul_sum = r_q[0] ? (r_acc + {1'b0, r_b}) : r_acc;
    assign w_trial   = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_diff    = {1'b0, w_trial} - {2'b00, r_b};

    assign w_prod     = {r_acc[WIDTH-1:0], r_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_q ? -r_q : r_q;
    assign w_rem_fix  = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = (w_is_div && w_b_zero) ? ST_DONE : ST_RUN;
            ST_RUN:   if (bus.abort) w_next = ST_IDLE;
                      else if (r_cnt == CW'(1)) w_next = ST_FIXUP;
            ST_FIXUP: w_next = bus.abort ? ST_IDLE : ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_is_div   <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_b        <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_is_div <= w_is_div;
                    r_cnt    <= CW'(WIDTH);
                    r_acc    <= '0;
                    r_q      <= w_a_mag;
                    r_b      <= w_b_mag;
                    r_neg_q  <= w_a_neg ^ w_b_neg;
                    r_neg_r  <= w_a_neg;
                    r_dz     <= w_is_div && w_b_zero;
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_is_div) begin
                        if (w_diff[WIDTH+1]) begin
                            r_acc <= w_trial;
                            r_q   <= {r_q[WIDTH-2:0], 1'b0};
                        end else begin
                            r_acc <= w_diff[WIDTH:0];
                            r_q   <= {r_q[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        r_acc <= {1'b0, w_mul_sum[WIDTH:1]};
                        r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
                    end
                end
                ST_FIXUP: begin
                    if (r_is_div) begin
                        r_acc <= {1'b0, w_rem_fix};
                        r_q   <= w_quo_fix;
                    end else begin
                        r_acc <= {1'b0, w_prod_fix[2*WIDTH-1:WIDTH]};
                        r_q   <= w_prod_fix[WIDTH-1:0];
                    end
                end
                ST_DONE: begin
                    r_done     <= 1'b1;
                    r_div_zero <= r_dz;
                    if (!r_dz) begin
                        r_hi <= r_acc[WIDTH-1:0];
                        r_lo <= r_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector table plus hand-written abort / busy-start / reset sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    muldiv_if #(.WIDTH(W)) bus();

    muldiv_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        op_e          op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op and wait for done; cyc counts edges from accept to done.
    task automatic run_op(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int cyc);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clock);
        #1 bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 60) begin
            @(posedge clock);
            #1 cyc++;
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int cyc;
        int seen;

        vecs[0]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
        vecs[2]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
        vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
        vecs[5]  = '{OP_DIV,   32'd5,        32'd0,        32'h00000000, 32'h80000000, 1'b1, 1};
        vecs[6]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 34};
        vecs[7]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34};
        vecs[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
        vecs[9]  = '{OP_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0, 34};
        vecs[10] = '{OP_DIVU,  32'd0,        32'd0,        32'h00000001, 32'h7FFFFFFC, 1'b1, 1};
        vecs[11] = '{OP_DIVU,  32'd3,        32'd5,        32'd3,        32'd0,        1'b0, 34};
        vecs[12] = '{OP_MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34};

        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.abort = 1'b0;

        #12;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_dz",   64'(bus.div_zero), 64'd0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            check($sformatf("v%0d_latency", i), 64'(cyc), 64'(vecs[i].cyc));
            check($sformatf("v%0d_hi", i), 64'(bus.hi), 64'(vecs[i].hi));
            check($sformatf("v%0d_lo", i), 64'(bus.lo), 64'(vecs[i].lo));
            check($sformatf("v%0d_dz", i), 64'(bus.div_zero), 64'(vecs[i].dz));
            check($sformatf("v%0d_idle_at_done", i), 64'(bus.busy), 64'd0);
            wait_cycles(1);
            check($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'd0);
        end

        // Abort at RUN cycle 10: hi/lo from the last vector must survive.
        @(negedge clock);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a_in = 32'hFFFFFFFF; bus.b_in = 32'hFFFFFFFF;
        @(posedge clock);
        #1 bus.start = 1'b0;
        check("abort_busy_run", 64'(bus.busy), 64'd1);
        wait_cycles(9);
        @(negedge clock);
        bus.abort = 1'b1;
        @(posedge clock);
        #1 bus.abort = 1'b0;
        check("abort_busy_low", 64'(bus.busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1 if (bus.done) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        check("abort_hilo_held", {bus.hi, bus.lo}, 64'hFFFFFFFF_00000000);

        // Abort wins over start in IDLE.
        @(negedge clock);
        bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0; bus.abort = 1'b0;
        check("abort_over_start", 64'(bus.busy), 64'd0);

        // Start while busy is dropped; only the first op completes.
        @(negedge clock);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a_in = 32'd3; bus.b_in = 32'd5;
        @(posedge clock);
        #1 bus.start = 1'b0;
        wait_cycles(4);
        @(negedge clock);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a_in = 32'd100; bus.b_in = 32'd7;
        @(posedge clock);
        #1 bus.start = 1'b0;
        cyc = 5;
        while (!bus.done && cyc < 60) begin
            @(posedge clock);
            #1 cyc++;
        end
        check("busy_start_latency", 64'(cyc), 64'd34);
        check("busy_start_result", {bus.hi, bus.lo}, {32'd0, 32'd15});
        wait_cycles(2);
        check("busy_start_not_queued", 64'(bus.busy), 64'd0);

        // Abort during DONE is ignored.
        @(negedge clock);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a_in = 32'd100; bus.b_in = 32'd7;
        @(posedge clock);
        #1 bus.start = 1'b0;
        wait_cycles(33);
        @(negedge clock);
        bus.abort = 1'b1;
        @(posedge clock);
        #1 bus.abort = 1'b0;
        check("abort_in_done_pulse", 64'(bus.done), 64'd1);
        check("abort_in_done_result", {bus.hi, bus.lo}, {32'd2, 32'd14});

        // Async reset mid-RUN clears outputs without waiting for an edge.
        @(negedge clock);
        bus.start = 1'b1; bus.op = OP_MULT; bus.a_in = 32'd7; bus.b_in = 32'd9;
        @(posedge clock);
        #1 bus.start = 1'b0;
        wait_cycles(10);
        #1 reset = 1'b1;
        #1;
        check("areset_busy", 64'(bus.busy), 64'd0);
        check("areset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("areset_done_dz", {62'd0, bus.done, bus.div_zero}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1 if (bus.done) seen++;
        end
        check("areset_no_done", 64'(seen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; even, >= 4.
REQ-002 Parameter: SIGNED_EN, default 1; 0 = signed ops execute as unsigned.
REQ-003 Port: clock  in  1  sole clock; all state rises on posedge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: start  in  1  request; sampled only in IDLE.
REQ-006 Port: op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; captured with start.
REQ-007 Port: a_in  in  WIDTH  multiplicand/dividend; captured with start.
REQ-008 Port: b_in  in  WIDTH  multiplier/divisor; captured with start.
REQ-009 Port: abort  in  1  cancels the operation in flight.
REQ-010 Port: busy  out  1  high in every state except IDLE.
REQ-011 Port: done  out  1  one-cycle completion pulse.
REQ-012 Port: div_zero  out  1  valid with done; divide with b = 0.
REQ-013 Port: hi  out  WIDTH  product upper half / remainder.
REQ-014 Port: lo  out  WIDTH  product lower half / quotient.

Function
REQ-015 FSM states: IDLE, RUN, FIXUP, DONE; encoding from package.
REQ-016 IDLE & start: latch op; latch |a|, |b| (magnitudes for signed ops); load iteration counter = WIDTH; go RUN.
REQ-017 IDLE & start & op is DIV/DIVU & b_in = 0: go DONE directly; div_zero = 1 in DONE; hi/lo unchanged.
REQ-018 RUN: one radix-2 step per cycle (shift-add multiply, restoring divide); counter decrements; go FIXUP when counter reaches 1 and that step completes.
REQ-019 FIXUP (1 cycle): signed ops negate product when a_sign XOR b_sign; negate quotient when a_sign XOR b_sign; remainder takes dividend sign.
REQ-020 DONE (1 cycle): done = 1; hi/lo load results; return to IDLE.
REQ-021 Latency: done asserted exactly WIDTH+2 cycles after the accepting edge; divide-by-zero: 1 cycle.
REQ-022 hi/lo change only in the DONE cycle; held at all other times, including across abort.
REQ-023 start while busy is ignored; no queueing.
REQ-024 abort in RUN or FIXUP: go IDLE next edge; no done pulse; hi/lo hold. Abort in DONE ignored (done still pulses). Abort takes priority over start in IDLE.
REQ-025 Signed overflow case (most-negative / -1): quotient = most-negative value (wrap), remainder = 0; no flag.
REQ-026 Multiply result is full 2*WIDTH bits; no overflow possible.
REQ-027 div_zero = 0 on every non-divide-by-zero done; held until next done.

Reset
REQ-028 reset forces IDLE, counter 0, busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0, regardless of clock; reset mid-operation discards it without a done pulse.

Structure
REQ-029 Shared package muldiv_pkg: op encodings (MULT, MULTU, DIV, DIVU) and the FSM state typedef; the CPU control FSM imports the same op constants.
REQ-030 Single flat module; no sub-module. The negate/sign-fixup logic is internal combinational logic, not a separate module.

Verification (WIDTH = 32)
REQ-031 MULT a = 7, b = 0xFFFFFFFD -> done at cycle 34 after accept; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001; DIVU 100 / 7 -> lo = 14, hi = 2.
REQ-033 DIV 0xFFFFFFF9 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-034 DIV 5 / 0 -> done 1 cycle after accept, div_zero = 1, hi/lo unchanged from prior values.
REQ-035 Abort at RUN cycle 10 -> busy low next cycle, no done, hi/lo held. Then start during busy -> ignored. Then async reset mid-RUN -> all outputs 0 immediately.
